// File: rtl/axi4_mem_pkg.sv
// Shared types and constants for the AXI4-to-single-port-RAM bridge.
package axi4_mem_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } state_t;

    // Number of byte-offset bits stripped from an AXI address to form a word address.
    function automatic int byte_off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the side not granted last wins.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req_w,
    input  logic req_r,
    input  logic accept,
    output logic grant_w,
    output logic grant_r
);

    logic last_read;

    assign grant_w = req_w && (!req_r || last_read);
    assign grant_r = req_r && (!req_w || !last_read);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_read <= 1'b0;
        end else if (accept) begin
            last_read <= grant_r;
        end
    end

endmodule

// File: rtl/axi4_mem_arbiter.sv
// AXI4 slave serving one burst at a time from a single-port RAM, arbitrating AW vs AR.
// Optional macro AXI_MEM_RANGE_CHECK_EN: bursts starting beyond the RAM return DECERR.
module axi4_mem_arbiter
    import axi4_mem_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int MEM_AW = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  aw_valid,
    output logic                  aw_ready,
    input  logic [ID_W-1:0]       aw_id,
    input  logic [ADDR_W-1:0]     aw_addr,
    input  logic [7:0]            aw_len,
    input  logic [1:0]            aw_burst,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [DATA_W-1:0]     w_data,
    input  logic [DATA_W/8-1:0]   w_strb,
    input  logic                  w_last,
    output logic                  b_valid,
    input  logic                  b_ready,
    output logic [ID_W-1:0]       b_id,
    output logic [1:0]            b_resp,
    input  logic                  ar_valid,
    output logic                  ar_ready,
    input  logic [ID_W-1:0]       ar_id,
    input  logic [ADDR_W-1:0]     ar_addr,
    input  logic [7:0]            ar_len,
    input  logic [1:0]            ar_burst,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic [ID_W-1:0]       r_id,
    output logic [DATA_W-1:0]     r_data,
    output logic [1:0]            r_resp,
    output logic                  r_last,
    output logic                  mem_en,
    output logic [DATA_W/8-1:0]   mem_we,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int OFF_W = byte_off_w(DATA_W);

    state_t              state, state_nx;
    logic [ID_W-1:0]     id_q;
    logic [MEM_AW-1:0]   addr_q;
    logic [7:0]          len_q;
    logic [7:0]          beat_q;
    logic                err_q;
    logic                fresh_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                grant_w, grant_r;
    logic [ADDR_W-1:0]   sel_addr, sel_word;
    logic                sel_err;
    logic                unused_ok;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_w   (aw_valid),
        .req_r   (ar_valid),
        .accept  ((aw_valid && aw_ready) || (ar_valid && ar_ready)),
        .grant_w (grant_w),
        .grant_r (grant_r)
    );

    assign sel_addr = grant_r ? ar_addr : aw_addr;
    assign sel_word = sel_addr >> OFF_W;
`ifdef AXI_MEM_RANGE_CHECK_EN
    assign sel_err  = |(sel_word >> MEM_AW);
`else
    assign sel_err  = 1'b0;
`endif
    assign unused_ok = ^{aw_burst, ar_burst, sel_word};

    assign b_id   = id_q;
    assign r_id   = id_q;
    assign b_resp = err_q ? DECERR : OKAY;
    assign r_resp = err_q ? DECERR : OKAY;
    // RAM data is live only in the first RD_DATA cycle; afterwards the captured copy holds it stable.
    assign r_data = err_q ? '0 : (fresh_q ? mem_rdata : rdata_q);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx  = state;
        aw_ready  = 1'b0;
        ar_ready  = 1'b0;
        w_ready   = 1'b0;
        b_valid   = 1'b0;
        r_valid   = 1'b0;
        r_last    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = addr_q;
        mem_wdata = w_data;
        if (!rst) begin
            case (state)
                IDLE: begin
                    aw_ready = grant_w;
                    ar_ready = grant_r;
                    if (grant_w)      state_nx = WR_DATA;
                    else if (grant_r) state_nx = RD_ADDR;
                end
                WR_DATA: begin
                    w_ready = 1'b1;
                    if (w_valid) begin
                        mem_en = !err_q;
                        mem_we = err_q ? '0 : w_strb;
                        if (w_last || beat_q == len_q) state_nx = WR_RESP;
                    end
                end
                WR_RESP: begin
                    b_valid = 1'b1;
                    if (b_ready) state_nx = IDLE;
                end
                RD_ADDR: begin
                    mem_en   = 1'b1;
                    state_nx = RD_DATA;
                end
                RD_DATA: begin
                    r_valid = 1'b1;
                    r_last  = (beat_q == len_q);
                    if (r_ready) state_nx = r_last ? IDLE : RD_ADDR;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            fresh_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state   <= state_nx;
            fresh_q <= (state == RD_ADDR);
            if (fresh_q) rdata_q <= mem_rdata;
            case (state)
                IDLE: begin
                    if (grant_w || grant_r) begin
                        id_q   <= grant_r ? ar_id : aw_id;
                        len_q  <= grant_r ? ar_len : aw_len;
                        addr_q <= sel_word[MEM_AW-1:0];
                        beat_q <= '0;
                        err_q  <= sel_err;
                    end
                end
                WR_DATA: begin
                    if (w_valid) begin
                        addr_q <= addr_q + 1'b1;
                        beat_q <= beat_q + 8'd1;
                    end
                end
                RD_DATA: begin
                    if (r_ready && !r_last) begin
                        addr_q <= addr_q + 1'b1;
                        beat_q <= beat_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_mem_arbiter.sv
// Scoreboard bench for axi4_mem_arbiter with a behavioural single-port RAM.
module tb_axi4_mem_arbiter;

    localparam int ID_W = 4, ADDR_W = 32, DATA_W = 64, MEM_AW = 14;

    typedef struct { logic [13:0] addr; logic [63:0] data; logic [7:0] strb; } wexp_t;
    typedef struct { logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; } rexp_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;

    logic clk = 1'b0;
    logic rst;
    logic aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
    logic ar_valid, ar_ready, r_valid, r_ready, r_last, mem_en;
    logic [3:0]  aw_id, ar_id, b_id, r_id;
    logic [31:0] aw_addr, ar_addr;
    logic [7:0]  aw_len, ar_len, w_strb, mem_we;
    logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
    logic [63:0] w_data, r_data, mem_wdata, mem_rdata;
    logic [13:0] mem_addr;

    logic [63:0] ram [0:(1<<MEM_AW)-1];
    logic [63:0] model [int];
    wexp_t wq[$];
    rexp_t rq[$];
    bexp_t bq[$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    axi4_mem_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_AW(MEM_AW)) dut (
        .clk(clk), .rst(rst),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
        .aw_len(aw_len), .aw_burst(aw_burst),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
        .ar_len(ar_len), .ar_burst(ar_burst),
        .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data),
        .r_resp(r_resp), .r_last(r_last),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we != 8'h00) begin
                for (int b = 0; b < 8; b++) begin
                    if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                end
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    function automatic bit is_err(input logic [31:0] a);
`ifdef AXI_MEM_RANGE_CHECK_EN
        return (a >> 3) >= 32'h0000_4000;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [13:0] word_of(input logic [31:0] a);
        logic [31:0] t;
        t = a >> 3;
        return t[13:0];
    endfunction

    task automatic aw_phase(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        bit ok = 0;
        aw_valid = 1; aw_id = id; aw_addr = addr; aw_len = len; aw_burst = 2'b01;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (aw_ready) begin ok = 1; break; end
        end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL aw_handshake: aw_ready=0, required 1"); end
        @(posedge clk); #1;
        aw_valid = 0;
    endtask

    task automatic ar_phase(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        bit ok = 0;
        ar_valid = 1; ar_id = id; ar_addr = addr; ar_len = len; ar_burst = 2'b10;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ar_ready) begin ok = 1; break; end
        end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL ar_handshake: ar_ready=0, required 1"); end
        @(posedge clk); #1;
        ar_valid = 0;
    endtask

    // Drives nbeats W beats; give_last marks the final beat, want_b collects the response.
    task automatic w_phase(input logic [3:0] id, input logic [31:0] addr, input int nbeats,
                           input logic [7:0] strb, input bit give_last, input bit want_b);
        bit          err = is_err(addr);
        logic [13:0] w = word_of(addr);
        logic [63:0] data, merged;
        wexp_t       e;
        bexp_t       be;
        bit          ok = 0;
        for (int b = 0; b < nbeats; b++) begin
            data = {$urandom, $urandom};
            if (!err) begin
                wq.push_back('{w, data, strb});
                merged = model.exists(int'(w)) ? model[int'(w)] : 64'h0;
                for (int k = 0; k < 8; k++) if (strb[k]) merged[k*8 +: 8] = data[k*8 +: 8];
                model[int'(w)] = merged;
            end
            w_valid = 1; w_data = data; w_strb = strb; w_last = give_last && (b == nbeats - 1);
            @(negedge clk);
            n_cmp++;
            if (w_ready !== 1'b1) begin n_bad++; $display("FAIL w_ready beat%0d: got %b, required 1", b, w_ready); end
            n_cmp++;
            if (mem_en !== (wq.size() != 0)) begin
                n_bad++;
                $display("FAIL wr_mem_en beat%0d: got %b, required %b", b, mem_en, wq.size() != 0);
            end
            if (wq.size() != 0) begin
                e = wq.pop_front();
                n_cmp++;
                if ({mem_we, mem_addr, mem_wdata} !== {e.strb, e.addr, e.data}) begin
                    n_bad++;
                    $display("FAIL wr_beat%0d: got we=%h addr=%h data=%h, required we=%h addr=%h data=%h",
                             b, mem_we, mem_addr, mem_wdata, e.strb, e.addr, e.data);
                end
            end
            @(posedge clk); #1;
            w = w + 14'd1;
        end
        w_valid = 0; w_last = 0;
        if (want_b) begin
            bq.push_back('{id, err ? 2'b11 : 2'b00});
            b_ready = 1;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (b_valid) begin ok = 1; break; end
            end
            be = bq.pop_front();
            n_cmp++;
            if (!ok) begin
                n_bad++; $display("FAIL b_timeout: b_valid=0, required 1");
            end else if ({b_id, b_resp} !== {be.id, be.resp}) begin
                n_bad++;
                $display("FAIL b_resp: got id=%h resp=%b, required id=%h resp=%b", b_id, b_resp, be.id, be.resp);
            end
            @(posedge clk); #1;
            b_ready = 0;
        end
    endtask

    // Collects len+1 beats; r_ready is held low for stall_n data-valid cycles at beat stall_beat.
    task automatic r_phase(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int stall_beat, input int stall_n);
        bit          err = is_err(addr);
        logic [13:0] w = word_of(addr);
        rexp_t       e;
        int beats = 0, stalls = 0, men = 0, cyc = 0;
        bit done = 0;
        for (int i = 0; i <= len; i++) begin
            rq.push_back('{id, err ? 64'h0 : model[int'(w)], err ? 2'b11 : 2'b00, i == len});
            w = w + 14'd1;
        end
        r_ready = !(stall_beat == 0 && stall_n > 0);
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            cyc++;
            if (mem_en) men++;
            if (r_valid && !r_ready && rq.size() != 0) begin
                stalls++;
                n_cmp++;
                if (r_data !== rq[0].data) begin
                    n_bad++; $display("FAIL r_stall_data: got %h, required %h", r_data, rq[0].data);
                end
            end
            if (r_valid && r_ready && rq.size() != 0) begin
                e = rq.pop_front();
                n_cmp++;
                if ({r_id, r_data, r_resp, r_last} !== {e.id, e.data, e.resp, e.last}) begin
                    n_bad++;
                    $display("FAIL r_beat%0d: got id=%h data=%h resp=%b last=%b, required id=%h data=%h resp=%b last=%b",
                             beats, r_id, r_data, r_resp, r_last, e.id, e.data, e.resp, e.last);
                end
                beats++;
                if (e.last) done = 1;
            end
            @(posedge clk); #1;
            r_ready = !(beats == stall_beat && stalls < stall_n);
        end
        r_ready = 0;
        rq.delete();
        n_cmp++;
        if (!done) begin n_bad++; $display("FAIL r_timeout: beats=%0d, required %0d", beats, len + 1); end
        n_cmp++;
        if (cyc != 2 * (len + 1) + stall_n) begin
            n_bad++; $display("FAIL r_cycles: got %0d, required %0d", cyc, 2 * (len + 1) + stall_n);
        end
        n_cmp++;
        if (men != len + 1) begin n_bad++; $display("FAIL r_mem_en_count: got %0d, required %0d", men, len + 1); end
    endtask

    task automatic test_reset;
        rst = 1; aw_valid = 1; ar_valid = 1;
        @(negedge clk);
        n_cmp++;
        if ({aw_ready, ar_ready, mem_en} !== 3'b000) begin
            n_bad++; $display("FAIL rst_ready: got %b, required 000", {aw_ready, ar_ready, mem_en});
        end
        @(posedge clk); #1;
        aw_valid = 0; ar_valid = 0;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        n_cmp++;
        if ({aw_ready, ar_ready, w_ready, b_valid, r_valid, mem_en} !== 6'b0) begin
            n_bad++;
            $display("FAIL rst_valids: got %b, required 000000", {aw_ready, ar_ready, w_ready, b_valid, r_valid, mem_en});
        end
        n_cmp++;
        if ({b_resp, r_resp, b_id, r_id, r_data} !== 76'h0) begin
            n_bad++;
            $display("FAIL rst_regs: got b_resp=%b r_resp=%b b_id=%h r_id=%h r_data=%h, required all 0",
                     b_resp, r_resp, b_id, r_id, r_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_write;
        aw_phase(4'd3, 32'h40, 8'd0);
        w_phase(4'd3, 32'h40, 1, 8'hFF, 1'b1, 1'b1);
        ar_phase(4'd3, 32'h40, 8'd0);
        r_phase(4'd3, 32'h40, 0, -1, 0);
    endtask

    task automatic test_read_burst;
        aw_phase(4'd1, 32'h0, 8'd3);
        w_phase(4'd1, 32'h0, 4, 8'hFF, 1'b1, 1'b1);
        ar_phase(4'd2, 32'h0, 8'd3);
        r_phase(4'd2, 32'h0, 3, -1, 0);
    endtask

    task automatic test_grant;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        aw_valid = 1; aw_id = 4'd9; aw_addr = 32'h48; aw_len = 8'd0;
        ar_valid = 1; ar_id = 4'd4; ar_addr = 32'h40; ar_len = 8'd0;
        @(negedge clk);
        n_cmp++;
        if ({aw_ready, ar_ready} !== 2'b01) begin
            n_bad++; $display("FAIL grant_first: got aw/ar ready %b, required 01", {aw_ready, ar_ready});
        end
        @(posedge clk); #1;
        aw_valid = 0; ar_valid = 0;
        r_phase(4'd4, 32'h40, 0, -1, 0);
        aw_valid = 1; ar_valid = 1;
        @(negedge clk);
        n_cmp++;
        if ({aw_ready, ar_ready} !== 2'b10) begin
            n_bad++; $display("FAIL grant_second: got aw/ar ready %b, required 10", {aw_ready, ar_ready});
        end
        @(posedge clk); #1;
        aw_valid = 0; ar_valid = 0;
        w_phase(4'd9, 32'h48, 1, 8'hFF, 1'b1, 1'b1);
    endtask

    task automatic test_read_stall;
        ar_phase(4'd5, 32'h0, 8'd3);
        r_phase(4'd5, 32'h0, 3, 2, 5);
    endtask

    task automatic test_burst_end;
        aw_phase(4'd6, 32'h100, 8'd3);
        w_phase(4'd6, 32'h100, 2, 8'hFF, 1'b1, 1'b1);
        aw_phase(4'd6, 32'h100, 8'd0);
        w_phase(4'd6, 32'h100, 1, 8'h0F, 1'b1, 1'b1);
        aw_phase(4'd7, 32'h200, 8'd1);
        w_phase(4'd7, 32'h200, 2, 8'hFF, 1'b0, 1'b1);
        ar_phase(4'd7, 32'h100, 8'd1);
        r_phase(4'd7, 32'h100, 1, -1, 0);
    endtask

    task automatic test_wrap;
        aw_phase(4'd8, 32'h0001_FFF8, 8'd1);
        w_phase(4'd8, 32'h0001_FFF8, 2, 8'hFF, 1'b1, 1'b1);
        ar_phase(4'd8, 32'h0001_FFF8, 8'd1);
        r_phase(4'd8, 32'h0001_FFF8, 1, -1, 0);
    endtask

    task automatic test_reset_mid_burst;
        aw_phase(4'd10, 32'h300, 8'd2);
        w_phase(4'd10, 32'h300, 2, 8'hFF, 1'b0, 1'b0);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        n_cmp++;
        if ({w_ready, b_valid, r_valid, mem_en} !== 4'b0) begin
            n_bad++;
            $display("FAIL mid_rst_idle: got w_ready/b_valid/r_valid/mem_en %b, required 0000",
                     {w_ready, b_valid, r_valid, mem_en});
        end
        @(posedge clk); #1;
        ar_phase(4'd11, 32'h300, 8'd1);
        r_phase(4'd11, 32'h300, 1, -1, 0);
    endtask

    task automatic test_range;
        aw_phase(4'd12, 32'h0002_0000, 8'd0);
        w_phase(4'd12, 32'h0002_0000, 1, 8'hFF, 1'b1, 1'b1);
        ar_phase(4'd12, 32'h0002_0000, 8'd0);
        r_phase(4'd12, 32'h0002_0000, 0, -1, 0);
    endtask

    initial begin
        rst = 1;
        {aw_valid, w_valid, w_last, b_ready, ar_valid, r_ready} = '0;
        aw_id = '0; ar_id = '0; aw_addr = '0; ar_addr = '0; aw_len = '0; ar_len = '0;
        aw_burst = '0; ar_burst = '0; w_data = '0; w_strb = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_write();
        test_read_burst();
        test_grant();
        test_read_stall();
        test_burst_end();
        test_wrap();
        test_reset_mid_burst();
        test_range();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
